uni_sr: RTL and testbench
=========================

# uni_sr

Universal bidirectional shift register: a parameterised, synchronous register with four modes (hold, shift right, shift left, parallel load), selected every clock cycle by a 2-bit mode input. It serves as a general-purpose datapath primitive for serial/parallel conversion and bit-stream alignment. Its parallel state is driven directly on its output.

## Interface
- WIDTH, default 8: register width in bits; legal values are 2 or more.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- m  input  2  mode select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sr  input  1  serial data entering the MSB during a shift right.
- sl  input  1  serial data entering the LSB during a shift left.
- ParIn  input  WIDTH  parallel load data.
- ParOut  output  WIDTH  current register contents.
- sout_r  output  1  only with UNI_SR_SERIAL_OUT_EN: the bit lost on the next shift right, equal to ParOut[0].
- sout_l  output  1  only with UNI_SR_SERIAL_OUT_EN: the bit lost on the next shift left, equal to ParOut[WIDTH-1].

## Operation
- A single WIDTH-bit register q drives ParOut, with no extra logic in between.
- On each rising clk edge, evaluated in priority order:
  - rst=1: q <= 0. Reset overrides every mode.
  - m=00 (hold): q <= q.
  - m=01 (shift right): q <= {sr, q[WIDTH-1:1]}. q[0] is discarded.
  - m=10 (shift left): q <= {q[WIDTH-2:0], sl}. q[WIDTH-1] is discarded.
  - m=11 (load): q <= ParIn.
- Serial inputs are ignored in every mode except their own shift direction.
- ParIn is ignored in every mode except load.
- Any X or Z on m is a protocol violation. The verification assertion flags it; the RTL does not define behaviour for it.

## Timing
- Fully synchronous. ParOut changes only after a rising clk edge, with a latency of one cycle from inputs to ParOut.
- Inputs are sampled at the rising edge and must meet setup/hold around it. Mode changes take effect at the first edge after the change.
- Before the first reset, ParOut is undefined. After rst is sampled high, ParOut is 0 from the next edge onward.
- If rst is asserted in the middle of a shift sequence, the shift data is lost and the register clears at that edge. The next operation starts from 0 on the first edge with rst=0.
- Consecutive shifts chain with no bubbles: N edges in shift mode move the contents N positions. After WIDTH or more shifts, the register holds only serial-input bits.
- sout_r and sout_l are combinational from q. They change together with ParOut and have no added latency.

## Configuration
- Macro: UNI_SR_SERIAL_OUT_EN.
- Defined: the ports sout_r and sout_l exist and behave as listed under Interface. This allows cascading by wiring one instance's sout_r to the next instance's sr.
- Not defined: sout_r and sout_l are absent from the port list. The register behaviour is otherwise identical.

## Test plan
- Reset: load ParIn=8'hA5, then assert rst with m=11 for one edge -> ParOut=8'h00 (reset wins over load). Deassert rst with m=00 -> ParOut stays 8'h00.
- Load then shift left: m=11, ParIn=8'hFF for two edges -> ParOut=8'hFF. Then m=10, sl=0 for two edges -> 8'hFE, then 8'hFC.
- Shift right, continuing from 8'hFC: m=01, sr=0 for two edges -> 8'h7E, then 8'h3F. Then m=00 for 5 edges -> ParOut holds 8'h3F.
- Serial fill: start from 8'h00, m=01, sr=1 for 8 edges -> 8'h80, 8'hC0, … , 8'hFF. Likewise m=10, sl=1 from 8'h00 -> 8'h01, 8'h03, … , 8'hFF.
- Ignored inputs:
  - In hold, toggle sl, sr and ParIn (for example to 8'h5A) -> ParOut unchanged.
  - In shift left, toggle sr -> no effect.
  - In shift right, toggle sl -> no effect.
- With UNI_SR_SERIAL_OUT_EN defined: load 8'h81 -> sout_r=1 and sout_l=1. One shift right with sr=0 -> ParOut=8'h40, sout_r=0, sout_l=0.

Source files
------------

// File: rtl/uni_sr.sv
// Universal bidirectional shift register: hold, shift right, shift left, parallel load.
// Optional serial outputs (sout_r, sout_l) are enabled by defining UNI_SR_SERIAL_OUT_EN.
module uni_sr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       m,
  input  logic             sr,
  input  logic             sl,
  input  logic [WIDTH-1:0] ParIn,
  output logic [WIDTH-1:0] ParOut
`ifdef UNI_SR_SERIAL_OUT_EN
  ,
  output logic             sout_r,
  output logic             sout_l
`endif
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHR   = 2'b01,
    MODE_SHL   = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;

  // NOTE: q_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    q_next = q;
    case (mode_e'(m))
      MODE_HOLD: q_next = q;
      MODE_SHR:  q_next = {sr, q[WIDTH-1:1]};
      MODE_SHL:  q_next = {q[WIDTH-2:0], sl};
      MODE_LOAD: q_next = ParIn;
      default:   q_next = q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= q_next;
  end

  assign ParOut = q;

`ifdef UNI_SR_SERIAL_OUT_EN
  // Bits that fall off the ends on the next shift; lets instances be chained sout_r -> sr.
  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];
`endif

  // An unknown mode has no defined behaviour, so flag it rather than let it propagate silently.
  a_mode_known : assert property (@(posedge clk) !$isunknown(m));

endmodule

// File: tb/tb_uni_sr.sv
// Self-checking bench for uni_sr (WIDTH=8): expected ParOut values are queued when stimulus
// is driven and popped/compared one cycle later, after the clock edge has updated the DUT.
module tb_uni_sr;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [1:0]       m;
  logic             sr;
  logic             sl;
  logic [WIDTH-1:0] ParIn;
  logic [WIDTH-1:0] ParOut;
`ifdef UNI_SR_SERIAL_OUT_EN
  logic             sout_r;
  logic             sout_l;
`endif

  int passed = 0;
  int total  = 0;

  logic [WIDTH-1:0] exp_q[$];

  uni_sr #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .m      (m),
    .sr     (sr),
    .sl     (sl),
    .ParIn  (ParIn),
    .ParOut (ParOut)
`ifdef UNI_SR_SERIAL_OUT_EN
    ,
    .sout_r (sout_r),
    .sout_l (sout_l)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, queue the expected result, and step past the edge.
  task automatic drive(input logic r, input logic [1:0] mm, input logic s_r, input logic s_l,
                       input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] e);
    rst   = r;
    m     = mm;
    sr    = s_r;
    sl    = s_l;
    ParIn = p;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] e;
    drive(1'b0, 2'b11, 1'b0, 1'b0, 8'hA5, 8'hA5);
    e = exp_q.pop_front(); total++;
    if (ParOut !== e) $display("FAIL reset_preload got=%h exp=%h", ParOut, e); else passed++;
    drive(1'b1, 2'b11, 1'b1, 1'b1, 8'hA5, 8'h00);
    e = exp_q.pop_front(); total++;
    if (ParOut !== e) $display("FAIL reset_over_load got=%h exp=%h", ParOut, e); else passed++;
    drive(1'b0, 2'b00, 1'b0, 1'b0, 8'hA5, 8'h00);
    e = exp_q.pop_front(); total++;
    if (ParOut !== e) $display("FAIL reset_then_hold got=%h exp=%h", ParOut, e); else passed++;
  endtask

  // sr toggled high during shift left must not leak into the register.
  task automatic test_load_shift_left();
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] seq [4] = '{8'hFF, 8'hFF, 8'hFE, 8'hFC};
    for (int i = 0; i < 4; i++) begin
      if (i < 2) drive(1'b0, 2'b11, 1'b0, 1'b0, 8'hFF, seq[i]);
      else       drive(1'b0, 2'b10, 1'b1, 1'b0, 8'h00, seq[i]);
      e = exp_q.pop_front(); total++;
      if (ParOut !== e) $display("FAIL load_shl step%0d got=%h exp=%h", i, ParOut, e);
      else passed++;
    end
  endtask

  // sl toggled high during shift right; then hold while every other input wiggles.
  task automatic test_shift_right_hold();
    logic [WIDTH-1:0] e;
    drive(1'b0, 2'b01, 1'b0, 1'b1, 8'h00, 8'h7E);
    e = exp_q.pop_front(); total++;
    if (ParOut !== e) $display("FAIL shr step0 got=%h exp=%h", ParOut, e); else passed++;
    drive(1'b0, 2'b01, 1'b0, 1'b1, 8'hFF, 8'h3F);
    e = exp_q.pop_front(); total++;
    if (ParOut !== e) $display("FAIL shr step1 got=%h exp=%h", ParOut, e); else passed++;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 2'b00, i[0], ~i[0], (i[0] ? 8'h5A : 8'hA5), 8'h3F);
      e = exp_q.pop_front(); total++;
      if (ParOut !== e) $display("FAIL hold cyc%0d got=%h exp=%h", i, ParOut, e); else passed++;
    end
  endtask

  // Fill from zero with serial ones in each direction, shifting past WIDTH.
  task automatic test_serial_fill();
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] ones = 8'hFF;
    drive(1'b1, 2'b01, 1'b1, 1'b1, 8'hFF, 8'h00);
    e = exp_q.pop_front(); total++;
    if (ParOut !== e) $display("FAIL fill_r_clear got=%h exp=%h", ParOut, e); else passed++;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 2'b01, 1'b1, 1'b0, 8'h00, (i < 8) ? ones << (7 - i) : ones);
      e = exp_q.pop_front(); total++;
      if (ParOut !== e) $display("FAIL fill_r step%0d got=%h exp=%h", i, ParOut, e); else passed++;
    end
    drive(1'b1, 2'b10, 1'b1, 1'b1, 8'hFF, 8'h00);
    e = exp_q.pop_front(); total++;
    if (ParOut !== e) $display("FAIL fill_l_clear got=%h exp=%h", ParOut, e); else passed++;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 2'b10, 1'b0, 1'b1, 8'h00, (i < 8) ? ones >> (7 - i) : ones);
      e = exp_q.pop_front(); total++;
      if (ParOut !== e) $display("FAIL fill_l step%0d got=%h exp=%h", i, ParOut, e); else passed++;
    end
  endtask

  // Reset in the middle of a shift sequence, then resume from zero.
  task automatic test_mid_shift_reset();
    logic [WIDTH-1:0] e;
    drive(1'b0, 2'b11, 1'b0, 1'b0, 8'hC3, 8'hC3);
    e = exp_q.pop_front(); total++;
    if (ParOut !== e) $display("FAIL midrst_load got=%h exp=%h", ParOut, e); else passed++;
    drive(1'b0, 2'b10, 1'b0, 1'b1, 8'h00, 8'h87);
    e = exp_q.pop_front(); total++;
    if (ParOut !== e) $display("FAIL midrst_shl got=%h exp=%h", ParOut, e); else passed++;
    drive(1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 8'h00);
    e = exp_q.pop_front(); total++;
    if (ParOut !== e) $display("FAIL midrst_clear got=%h exp=%h", ParOut, e); else passed++;
    drive(1'b0, 2'b10, 1'b0, 1'b1, 8'h00, 8'h01);
    e = exp_q.pop_front(); total++;
    if (ParOut !== e) $display("FAIL midrst_resume got=%h exp=%h", ParOut, e); else passed++;
  endtask

  // Random back-to-back operations against a small behavioural model.
  task automatic test_back_to_back();
    logic [WIDTH-1:0] model = 8'h01;
    logic [WIDTH-1:0] e;
    logic [1:0]       mm;
    logic             r, s_r, s_l;
    logic [WIDTH-1:0] p;
    for (int i = 0; i < 200; i++) begin
      r   = ($urandom_range(0, 19) == 0);
      mm  = 2'($urandom_range(0, 3));
      s_r = 1'($urandom_range(0, 1));
      s_l = 1'($urandom_range(0, 1));
      p   = 8'($urandom_range(0, 255));
      if (r)               model = 8'h00;
      else if (mm == 2'b01) model = {s_r, model[7:1]};
      else if (mm == 2'b10) model = {model[6:0], s_l};
      else if (mm == 2'b11) model = p;
      drive(r, mm, s_r, s_l, p, model);
      e = exp_q.pop_front(); total++;
      if (ParOut !== e)
        $display("FAIL b2b cyc%0d rst=%b m=%b got=%h exp=%h", i, r, mm, ParOut, e);
      else passed++;
    end
  endtask

`ifdef UNI_SR_SERIAL_OUT_EN
  task automatic test_serial_out();
    logic [WIDTH-1:0] e;
    drive(1'b0, 2'b11, 1'b0, 1'b0, 8'h81, 8'h81);
    e = exp_q.pop_front(); total++;
    if (ParOut !== e || sout_r !== 1'b1 || sout_l !== 1'b1)
      $display("FAIL sout_load got=%h/%b/%b exp=%h/1/1", ParOut, sout_r, sout_l, e);
    else passed++;
    drive(1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 8'h40);
    e = exp_q.pop_front(); total++;
    if (ParOut !== e || sout_r !== 1'b0 || sout_l !== 1'b0)
      $display("FAIL sout_shr got=%h/%b/%b exp=%h/0/0", ParOut, sout_r, sout_l, e);
    else passed++;
  endtask
`endif

  initial begin
    rst   = 1'b0;
    m     = 2'b00;
    sr    = 1'b0;
    sl    = 1'b0;
    ParIn = '0;
    #2;
    test_reset();
    test_load_shift_left();
    test_shift_right_hold();
    test_serial_fill();
    test_mid_shift_reset();
`ifdef UNI_SR_SERIAL_OUT_EN
    test_serial_out();
`endif
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
